// File: rtl/tlp_dispatcher.sv
// Round-robin burst dispatcher that drains four source FIFOs into one destination FIFO.
// Optional forwarded-word counter on port fwd_count, enabled by defining DISPATCH_CNT_EN.
module tlp_dispatcher #(
  parameter int BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  fifo_empty,
  input  logic [11:0] fifo_data0,
  input  logic [11:0] fifo_data1,
  input  logic [11:0] fifo_data2,
  input  logic [11:0] fifo_data3,
  input  logic        dest_almost_full,
  output logic [3:0]  pop,
  output logic        push,
  output logic [11:0] data_out,
  output logic        busy
`ifdef DISPATCH_CNT_EN
  ,
  output logic [7:0]  fwd_count
`endif
);

  localparam logic [2:0] BURST_MAX = 3'(BURST);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [1:0]  grant, grant_next;
  logic [1:0]  last_grant, last_grant_next;
  logic [2:0]  burst_cnt, burst_cnt_next;
  logic [1:0]  next_ch;
  logic [1:0]  cand;
  logic        found;
  logic        pop_any;
  logic        pop_v;
  logic [1:0]  sel;
  logic [11:0] sel_data;

  // Search starts just after the previous winner so every channel gets its turn.
  always_comb begin
    next_ch = last_grant;
    cand    = '0;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (!found && !fifo_empty[cand]) begin
        next_ch = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    burst_cnt_next  = burst_cnt;
    case (state)
      IDLE: begin
        if (found && !dest_almost_full) begin
          state_next     = XFER;
          grant_next     = next_ch;
          burst_cnt_next = '0;
        end
      end
      XFER: begin
        if (fifo_empty[grant] || burst_cnt == BURST_MAX) begin
          state_next      = IDLE;
          last_grant_next = grant;
        end else if (pop_any) begin
          burst_cnt_next = burst_cnt + 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop     = '0;
    pop_any = (state == XFER) && !reset && !fifo_empty[grant] &&
              !dest_almost_full && (burst_cnt < BURST_MAX);
    if (pop_any) pop[grant] = 1'b1;
  end

  always_comb begin
    case (sel)
      2'd0:    sel_data = fifo_data0;
      2'd1:    sel_data = fifo_data1;
      2'd2:    sel_data = fifo_data2;
      default: sel_data = fifo_data3;
    endcase
  end

  // Two-stage pipeline: the source presents data one cycle after pop, then it is registered out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 2'd0;
      last_grant <= 2'd3;
      burst_cnt  <= 3'd0;
      pop_v      <= 1'b0;
      sel        <= 2'd0;
      push       <= 1'b0;
      data_out   <= 12'd0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
      burst_cnt  <= burst_cnt_next;
      pop_v      <= pop_any;
      if (pop_any) sel <= grant;
      push       <= pop_v;
      if (pop_v) data_out <= sel_data;
    end
  end

  assign busy = (state == XFER) | pop_v | push;

`ifdef DISPATCH_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) fwd_count <= 8'd0;
    else if (push) fwd_count <= fwd_count + 8'd1;
  end
`endif

endmodule

// File: doc/tlp_dispatcher.md
TLP_DISPATCHER -- requirements
Module: tlp_dispatcher

Interface
REQ-001 SHALL have parameter BURST, default 4, max words popped per grant; legal range 1..7.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port fifo_empty  input  4  bit i high = source FIFO i holds no words.
REQ-005 SHALL have ports fifo_data0..fifo_data3  input  12 each  source FIFO read data; valid the cycle after its pop.
REQ-006 SHALL have port dest_almost_full  input  1  destination FIFO almost_full flag.
REQ-007 SHALL have port pop  output  4  one-hot pop to source FIFOs; at most one bit high.
REQ-008 SHALL have port push  output  1  registered push to destination FIFO.
REQ-009 SHALL have port data_out  output  12  registered word for destination; meaningful only while push=1.
REQ-010 SHALL have port busy  output  1  high while FSM is in XFER or pipeline holds words.

Function
REQ-011 SHALL implement a two-state FSM, IDLE and XFER, plus 2-bit grant, 2-bit last_grant, 3-bit burst_cnt.
REQ-012 IDLE: if any fifo_empty bit low and dest_almost_full=0, grant <= first non-empty channel after last_grant, wrapping 3->0; burst_cnt <= 0; go to XFER. Otherwise stay.
REQ-013 XFER: pop[grant] SHALL be high combinationally when fifo_empty[grant]=0, dest_almost_full=0 and burst_cnt<BURST; all other pop bits low.
REQ-014 Each cycle with pop high SHALL increment burst_cnt.
REQ-015 XFER SHALL exit to IDLE, with last_grant <= grant, when fifo_empty[grant]=1 or burst_cnt=BURST. Empty takes priority over a simultaneous stall.
REQ-016 XFER with dest_almost_full=1 and source not empty SHALL stall: no pop, stay in XFER, burst_cnt held.
REQ-017 pop SHALL be all-zero in IDLE.
REQ-018 Pipeline: pop in cycle N SHALL register pop_v/sel in N+1. In N+2, push=1 and data_out=fifo_data[sel] as sampled in N+1. Fixed latency is 2 cycles.
REQ-019 In-flight words SHALL always complete even if dest_almost_full rises. The destination almost_full threshold SHALL leave at least 2 free entries.
REQ-020 Word order per channel SHALL be preserved. No word is duplicated or dropped.
REQ-021 busy SHALL equal (state==XFER) | pop_v | push.

Reset
REQ-022 With reset=1 at a rising edge, the following SHALL hold on the next cycle: state=IDLE, grant=0, last_grant=3, burst_cnt=0, pop_v=0, push=0, data_out=0, busy=0. pop SHALL be 0 during and after reset.
REQ-023 Reset mid-transfer SHALL discard in-flight pipeline words. No push SHALL occur for pops issued before reset.
REQ-024 After reset the first grant SHALL go to the lowest-numbered non-empty channel.

Configuration
REQ-025 Macro DISPATCH_CNT_EN defined: SHALL add output fwd_count, 8 bits, reset 0, incrementing on every push=1 cycle, wrapping 255->0.
REQ-026 Macro DISPATCH_CNT_EN undefined: fwd_count port and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-027 Stimulus: reset, then channel 1 only non-empty with 3 words 0x111,0x112,0x113, dest_almost_full=0. Response: pop=0010 for 3 consecutive cycles, then push for 3 cycles starting 2 cycles after the first pop, same order, FSM back to IDLE.
REQ-028 Stimulus: all 4 channels hold 6 words, BURST=4. Response: grant order 0,1,2,3,0,1,2,3. First pass yields exactly 4 pops per channel, second pass 2.
REQ-029 Stimulus: dest_almost_full raised the cycle after the 2nd pop of a burst. Response: no further pop, exactly 2 pushes complete, FSM stays XFER. Popping resumes the cycle almost_full clears.
REQ-030 Stimulus: channel 2 goes empty after 1 word with BURST=4. Response: 1 pop, return to IDLE, last_grant=2, next grant goes to channel 3 if non-empty.
REQ-031 Stimulus: reset asserted one cycle after a pop. Response: push stays 0 and data_out=0 on the next cycles, busy=0, FSM in IDLE.
REQ-032 Stimulus: with DISPATCH_CNT_EN, forward 257 words. Response: fwd_count=1. Without the macro, the build contains no fwd_count.
